// File: rtl/psram_pkg.sv
// Shared types and command constants for the PSRAM command serializer.
// Optional build macro: PSRAM_ADDR_PHASE_EN (adds the ADDR state).
package psram_pkg;

`ifdef PSRAM_ADDR_PHASE_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        ADDR = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1
    } state_e;
`endif

    // Common PSRAM command opcodes
    localparam logic [7:0] RSTEN         = 8'h66;
    localparam logic [7:0] RST           = 8'h99;
    localparam logic [7:0] QPI_EN        = 8'h35;
    localparam logic [7:0] FAST_READ_QPI = 8'hEB;
    localparam logic [7:0] WRITE_QPI     = 8'h38;

    // Lane enables for one beat: lane 0 only in SPI, all four in QPI
    function automatic logic [3:0] lane_oe(input logic qpi);
        return qpi ? 4'b1111 : 4'b0001;
    endfunction

endpackage

// File: rtl/psram_cmd_serializer.sv
// Serializes a PSRAM command (and optionally an address) onto SPI/QPI lanes.
// Optional build macro: PSRAM_ADDR_PHASE_EN enables the address phase.
module psram_cmd_serializer
    import psram_pkg::*;
#(
    parameter int unsigned CMD_W  = 8,
    parameter int unsigned ADDR_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CMD_W-1:0]  command,
    input  logic [ADDR_W-1:0] addr,
    input  logic              has_addr,
    input  logic              qpi,
    input  logic              strobe,
    output logic              ready,
    output logic              done,
    output logic              ce_n,
    output logic [3:0]        sio_out,
    output logic [3:0]        sio_oe
);

`ifdef PSRAM_ADDR_PHASE_EN
    localparam int unsigned MAX_BEATS = (ADDR_W > CMD_W) ? ADDR_W : CMD_W;
`else
    localparam int unsigned MAX_BEATS = CMD_W;
`endif
    localparam int unsigned CNT_W = $clog2(MAX_BEATS);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CMD_W-1:0]   cmd_sh_q, cmd_sh_d;
    logic               qpi_q, qpi_d;
    logic               ce_n_q, ce_n_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic [3:0]         sio_out_q, sio_out_d;
    logic [3:0]         sio_oe_q, sio_oe_d;
    logic [CNT_W-1:0]   cmd_last_c;

`ifdef PSRAM_ADDR_PHASE_EN
    logic [ADDR_W-1:0]  addr_sh_q, addr_sh_d;
    logic               has_addr_q, has_addr_d;
    logic [CNT_W-1:0]   addr_last_c;
`else
    logic               unused_addr_c;
    assign unused_addr_c = ^{addr, has_addr};
`endif

    // Most significant beat of a word: one bit (SPI) or one nibble (QPI)
    function automatic logic [3:0] cmd_beat(input logic [CMD_W-1:0] w, input logic q);
        return q ? w[CMD_W-1 -: 4] : {3'b000, w[CMD_W-1]};
    endfunction

`ifdef PSRAM_ADDR_PHASE_EN
    function automatic logic [3:0] addr_beat(input logic [ADDR_W-1:0] w, input logic q);
        return q ? w[ADDR_W-1 -: 4] : {3'b000, w[ADDR_W-1]};
    endfunction
`endif

    // Index of the final beat in each phase for the latched lane mode
    always_comb begin
        cmd_last_c = qpi_q ? CNT_W'(CMD_W / 4 - 1) : CNT_W'(CMD_W - 1);
`ifdef PSRAM_ADDR_PHASE_EN
        addr_last_c = qpi_q ? CNT_W'(ADDR_W / 4 - 1) : CNT_W'(ADDR_W - 1);
`endif
    end

    // State, shifters, counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cmd_sh_q   <= '0;
            qpi_q      <= 1'b0;
            ce_n_q     <= 1'b1;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            sio_out_q  <= '0;
            sio_oe_q   <= '0;
`ifdef PSRAM_ADDR_PHASE_EN
            addr_sh_q  <= '0;
            has_addr_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cmd_sh_q   <= cmd_sh_d;
            qpi_q      <= qpi_d;
            ce_n_q     <= ce_n_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            sio_out_q  <= sio_out_d;
            sio_oe_q   <= sio_oe_d;
`ifdef PSRAM_ADDR_PHASE_EN
            addr_sh_q  <= addr_sh_d;
            has_addr_q <= has_addr_d;
`endif
        end
    end

    // Next state; outputs are computed one cycle ahead so the flops carry the beat
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_sh_d  = cmd_sh_q;
        qpi_d     = qpi_q;
        ce_n_d    = 1'b1;
        ready_d   = 1'b0;
        done_d    = 1'b0;
        sio_out_d = '0;
        sio_oe_d  = '0;
`ifdef PSRAM_ADDR_PHASE_EN
        addr_sh_d  = addr_sh_q;
        has_addr_d = has_addr_q;
`endif
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (strobe) begin
                    // Present the first command beat straight from the input word
                    state_d   = CMD;
                    cnt_d     = '0;
                    qpi_d     = qpi;
                    ce_n_d    = 1'b0;
                    ready_d   = 1'b0;
                    sio_out_d = cmd_beat(command, qpi);
                    sio_oe_d  = lane_oe(qpi);
                    cmd_sh_d  = qpi ? (command << 4) : (command << 1);
`ifdef PSRAM_ADDR_PHASE_EN
                    addr_sh_d  = addr;
                    has_addr_d = has_addr;
`endif
                end
            end
            CMD: begin
                if (cnt_q == cmd_last_c) begin
`ifdef PSRAM_ADDR_PHASE_EN
                    if (has_addr_q) begin
                        state_d   = ADDR;
                        cnt_d     = '0;
                        ce_n_d    = 1'b0;
                        sio_out_d = addr_beat(addr_sh_q, qpi_q);
                        sio_oe_d  = lane_oe(qpi_q);
                        addr_sh_d = qpi_q ? (addr_sh_q << 4) : (addr_sh_q << 1);
                    end else begin
                        state_d = IDLE;
                        ready_d = 1'b1;
                        done_d  = 1'b1;
                    end
`else
                    state_d = IDLE;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
`endif
                end else begin
                    cnt_d     = cnt_q + CNT_W'(1);
                    ce_n_d    = 1'b0;
                    sio_out_d = cmd_beat(cmd_sh_q, qpi_q);
                    sio_oe_d  = lane_oe(qpi_q);
                    cmd_sh_d  = qpi_q ? (cmd_sh_q << 4) : (cmd_sh_q << 1);
                end
            end
`ifdef PSRAM_ADDR_PHASE_EN
            ADDR: begin
                if (cnt_q == addr_last_c) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    cnt_d     = cnt_q + CNT_W'(1);
                    ce_n_d    = 1'b0;
                    sio_out_d = addr_beat(addr_sh_q, qpi_q);
                    sio_oe_d  = lane_oe(qpi_q);
                    addr_sh_d = qpi_q ? (addr_sh_q << 4) : (addr_sh_q << 1);
                end
            end
`endif
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    assign ready   = ready_q;
    assign done    = done_q;
    assign ce_n    = ce_n_q;
    assign sio_out = sio_out_q;
    assign sio_oe  = sio_oe_q;

endmodule

// File: tb/tb_psram_cmd_serializer.sv
// Self-checking bench for psram_cmd_serializer (default CMD_W=8, ADDR_W=24).
// Honours PSRAM_ADDR_PHASE_EN when the design is built with it.
module tb_psram_cmd_serializer;

    localparam int CW = 8;
    localparam int AW = 24;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CW-1:0] command;
    logic [AW-1:0] addr;
    logic          has_addr;
    logic          qpi;
    logic          strobe;
    logic          ready;
    logic          done;
    logic          ce_n;
    logic [3:0]    sio_out;
    logic [3:0]    sio_oe;

    int n_checks = 0;
    int n_err    = 0;

    psram_cmd_serializer #(.CMD_W(CW), .ADDR_W(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .command  (command),
        .addr     (addr),
        .has_addr (has_addr),
        .qpi      (qpi),
        .strobe   (strobe),
        .ready    (ready),
        .done     (done),
        .ce_n     (ce_n),
        .sio_out  (sio_out),
        .sio_oe   (sio_oe)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic exp_done);
        chk({tag, "_ce_n"},  32'(ce_n),    32'd1);
        chk({tag, "_ready"}, 32'(ready),   32'd1);
        chk({tag, "_done"},  32'(done),    32'(exp_done));
        chk({tag, "_out"},   32'(sio_out), 32'd0);
        chk({tag, "_oe"},    32'(sio_oe),  32'd0);
    endtask

    // Reference: ordered list of lane values a transfer must put on the bus
    task automatic expected_beats(input logic [CW-1:0] c, input logic [AW-1:0] a,
                                  input logic h, input logic q,
                                  output logic [3:0] beats[$]);
        int unsigned v;
        beats = {};
        if (q) begin
            for (int i = 0; i < CW / 4; i++) begin
                v = (32'(c) >> (CW - 4 - 4 * i)) & 32'hF;
                beats.push_back(v[3:0]);
            end
        end else begin
            for (int i = 0; i < CW; i++) begin
                v = (32'(c) >> (CW - 1 - i)) & 32'h1;
                beats.push_back(v[3:0]);
            end
        end
`ifdef PSRAM_ADDR_PHASE_EN
        if (h) begin
            if (q) begin
                for (int i = 0; i < AW / 4; i++) begin
                    v = (32'(a) >> (AW - 4 - 4 * i)) & 32'hF;
                    beats.push_back(v[3:0]);
                end
            end else begin
                for (int i = 0; i < AW; i++) begin
                    v = (32'(a) >> (AW - 1 - i)) & 32'h1;
                    beats.push_back(v[3:0]);
                end
            end
        end
`else
        if (h && (a != a)) beats.push_back(4'h0);
`endif
    endtask

    // Call right after a negedge with the DUT idle; ends on the done-cycle negedge
    // (plus one idle cycle unless the strobe is held for back-to-back).
    task automatic do_xfer(input logic [CW-1:0] c, input logic [AW-1:0] a,
                           input logic h, input logic q,
                           input bit hold, input bit disturb, input string tag);
        logic [3:0] beats[$];
        logic [3:0] oe_exp;
        expected_beats(c, a, h, q, beats);
        oe_exp   = q ? 4'hF : 4'h1;
        command  = c;
        addr     = a;
        has_addr = h;
        qpi      = q;
        strobe   = 1'b1;
        for (int i = 0; i < beats.size(); i++) begin
            @(negedge clk);
            chk($sformatf("%s_b%0d_ce_n", tag, i),  32'(ce_n),    32'd0);
            chk($sformatf("%s_b%0d_out", tag, i),   32'(sio_out), 32'(beats[i]));
            chk($sformatf("%s_b%0d_oe", tag, i),    32'(sio_oe),  32'(oe_exp));
            chk($sformatf("%s_b%0d_ready", tag, i), 32'(ready),   32'd0);
            chk($sformatf("%s_b%0d_done", tag, i),  32'(done),    32'd0);
            if (!hold) strobe = 1'b0;
            if (disturb && i == 2) begin
                command  = ~c;
                addr     = ~a;
                has_addr = ~h;
                qpi      = ~q;
                strobe   = 1'b1;
            end
            if (disturb && i == 3) strobe = 1'b0;
        end
        @(negedge clk);
        chk_idle({tag, "_donecyc"}, 1'b1);
        if (!hold) begin
            @(negedge clk);
            chk_idle({tag, "_after"}, 1'b0);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        command  = '0;
        addr     = '0;
        has_addr = 1'b0;
        qpi      = 1'b0;
        strobe   = 1'b0;

        // Reset state, with a strobe pending that must not be taken
        repeat (2) @(negedge clk);
        strobe = 1'b1;
        @(negedge clk);
        chk_idle("reset", 1'b0);
        strobe = 1'b0;

        // Strobe on the very first edge after release: SPI RSTEN
        rst_n = 1'b1;
        do_xfer(8'h66, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0, "spi66");

        // QPI enable opcode, two nibbles
        do_xfer(8'h35, 24'h0, 1'b0, 1'b1, 1'b0, 1'b0, "qpi35");

        // QPI fast read with address
        do_xfer(8'hEB, 24'h123456, 1'b1, 1'b1, 1'b0, 1'b0, "qpiEB");

        // SPI with address phase requested
        do_xfer(8'h38, 24'hA5C30F, 1'b1, 1'b0, 1'b0, 1'b0, "spi38a");

        // Strobe held high: back-to-back with a single ce_n-high cycle
        do_xfer(8'h99, 24'h0, 1'b0, 1'b0, 1'b1, 1'b0, "b2b1");
        do_xfer(8'h99, 24'h0, 1'b0, 1'b0, 1'b1, 1'b0, "b2b2");
        strobe = 1'b0;
        @(negedge clk);
        chk_idle("b2b_end", 1'b0);

        // Competing strobe with other inputs mid-transfer is ignored
        do_xfer(8'hC3, 24'h0, 1'b0, 1'b0, 1'b0, 1'b1, "dist");

        // Asynchronous reset during the third SPI beat
        command  = 8'h66;
        has_addr = 1'b0;
        qpi      = 1'b0;
        strobe   = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_pre_ce_n", 32'(ce_n), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("midrst", 1'b0);
        @(negedge clk);
        chk_idle("midrst_hold", 1'b0);
        rst_n = 1'b1;
        do_xfer(8'h99, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0, "postrst");

        // Randomised transfers against the reference
        for (int t = 0; t < 24; t++) begin
            logic [CW-1:0] rc;
            logic [AW-1:0] ra;
            logic          rh;
            logic          rq;
            rc = CW'($urandom);
            ra = AW'($urandom);
            rh = 1'($urandom_range(0, 1));
            rq = 1'($urandom_range(0, 1));
            do_xfer(rc, ra, rh, rq, 1'b0, (t % 5 == 0) && !rq, $sformatf("rnd%0d", t));
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                chk_idle($sformatf("rnd%0d_gap", t), 1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
